lemming_dig_scheduler: RTL and testbench

Arbitrates a single shared "dig" permission among N lemming walker FSMs so that at most one lemming digs at a time. Round-robin selection among requesters; drives the chosen lemming's dig input, waits for its digging acknowledge, tracks the dig until it ends, then enforces a cooldown before the next grant. Sits between the level/player logic, which produces dig requests, and the array of lemming FSMs.

---
 rtl/lemming_pkg.sv | 32 +++
 rtl/lemming_dig_scheduler_rr_pick.sv | 35 +++
 rtl/lemming_dig_scheduler.sv | 160 ++++++++++++++++
 tb/tb_lemming_dig_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lemming_pkg.sv
// lemming_pkg: shared types and constants for the lemming block.
//   sched_state_t    : dig scheduler FSM states (IDLE, GRANT, ACTIVE, COOL).
//   walker_state_t   : lemming walker FSM encoding.
//   DEF_*            : default parameter values for lemming_dig_scheduler.
//   FALL_DEATH_CYCLES: fall length at which a walker dies on landing.
package lemming_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACTIVE = 2'd2,
        COOL   = 2'd3
    } sched_state_t;

    typedef enum logic [2:0] {
        WL    = 3'd0,
        WR    = 3'd1,
        FALLL = 3'd2,
        FALLR = 3'd3,
        DIGL  = 3'd4,
        DIGR  = 3'd5,
        DEAD  = 3'd6
    } walker_state_t;

    localparam int FALL_DEATH_CYCLES = 20;

    localparam int DEF_N           = 4;
    localparam int DEF_ACK_TIMEOUT = 4;
    localparam int DEF_MAX_DIG     = 20;
    localparam int DEF_COOLDOWN    = 2;

endpackage

// File: rtl/lemming_dig_scheduler_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req        in  N   request vector
//   last_owner in  OW  index granted last; scan starts at last_owner+1
//   valid      out 1   any request present
//   index      out OW  first set request scanning last_owner+1 .. last_owner+N (mod N)
module rr_pick #(
    parameter  int N  = 4,
    localparam int OW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] last_owner,
    output logic          valid,
    output logic [OW-1:0] index
);

    always_comb begin
        int            w_c;
        logic [OW-1:0] w_cand;
        valid  = 1'b0;
        index  = '0;
        w_c    = 0;
        w_cand = '0;
        // i = N wraps back to last_owner itself, so a lone repeat requester still wins.
        for (int i = 1; i <= N; i++) begin
            w_c = int'(last_owner) + i;
            if (w_c >= N) w_c = w_c - N;
            w_cand = OW'(w_c);
            if (!valid && req[w_cand]) begin
                valid = 1'b1;
                index = w_cand;
            end
        end
    end

endmodule

// File: rtl/lemming_dig_scheduler.sv
// lemming_dig_scheduler: grants a single shared dig permission to one of N
// lemmings at a time (round robin), waits for the digging ack, tracks the dig
// and enforces a cooldown before the next grant.
//   clk, areset        clock, async active-high reset
//   req[N]             per-lemming dig request (level, not latched)
//   digging[N]         per-lemming digging status
//   dig[N]             one-hot-or-zero dig command
//   busy               FSM not in IDLE
//   owner[OW]          current / last grantee
//   done               pulse: owner stopped digging in ACTIVE
//   ack_timeout        pulse: grant abandoned without ack
//   overrun            pulse: dig length reached MAX_DIG
// Optional (macro DIG_SCHED_STATS_EN): grant_cnt[8], timeout_cnt[8], saturating.
module lemming_dig_scheduler
    import lemming_pkg::*;
#(
    parameter  int N           = DEF_N,
    parameter  int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter  int MAX_DIG     = DEF_MAX_DIG,
    parameter  int COOLDOWN    = DEF_COOLDOWN,
    localparam int OW          = $clog2(N)
) (
    input  logic          clk,
    input  logic          areset,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  digging,
    output logic [N-1:0]  dig,
    output logic          busy,
    output logic [OW-1:0] owner,
    output logic          done,
    output logic          ack_timeout,
    output logic          overrun
`ifdef DIG_SCHED_STATS_EN
    ,
    output logic [7:0]    grant_cnt,
    output logic [7:0]    timeout_cnt
`endif
);

    sched_state_t  r_state;
    logic [N-1:0]  r_dig;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] r_last_owner;
    logic [7:0]    r_cnt;
    logic          r_done;
    logic          r_ack_timeout;
    logic          r_overrun;

    logic          w_pick_valid;
    logic [OW-1:0] w_pick_idx;
    logic          w_own_digging;
    logic [N-1:0]  w_owner_1h;
    logic          w_grant_start;
    logic          w_timeout;

    rr_pick #(.N(N)) u_pick (
        .req        (req),
        .last_owner (r_last_owner),
        .valid      (w_pick_valid),
        .index      (w_pick_idx)
    );

    assign w_own_digging = digging[r_owner];
    assign w_owner_1h    = N'(1) << r_owner;
    assign w_grant_start = (r_state == IDLE) && w_pick_valid;
    // The ack window only runs while dig is actually driven, so dig stays
    // high for exactly ACK_TIMEOUT cycles before the grant is abandoned.
    assign w_timeout     = (r_state == GRANT) && !w_own_digging && (r_dig != '0)
                           && (r_cnt == 8'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state       <= IDLE;
            r_dig         <= '0;
            r_owner       <= '0;
            r_last_owner  <= OW'(N - 1);
            r_cnt         <= '0;
            r_done        <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_overrun     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_own_digging) begin
                        r_dig   <= '0;
                        r_cnt   <= '0;
                        r_state <= ACTIVE;
                    end else if (w_timeout) begin
                        r_dig         <= '0;
                        r_cnt         <= '0;
                        r_ack_timeout <= 1'b1;
                        r_last_owner  <= r_owner;
                        r_state       <= COOL;
                    end else begin
                        r_dig <= w_owner_1h;
                        if (r_dig != '0) r_cnt <= r_cnt + 8'd1;
                    end
                end
                ACTIVE: begin
                    // Length tracking runs even on the exit cycle so done and
                    // overrun can pulse together.
                    if (r_cnt != 8'(MAX_DIG)) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == 8'(MAX_DIG - 1)) r_overrun <= 1'b1;
                    end
                    if (!w_own_digging) begin
                        r_done       <= 1'b1;
                        r_cnt        <= '0;
                        r_last_owner <= r_owner;
                        r_state      <= COOL;
                    end
                end
                COOL: begin
                    if (r_cnt == 8'(COOLDOWN)) r_state <= IDLE;
                    else                       r_cnt   <= r_cnt + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DIG_SCHED_STATS_EN
    logic [7:0] r_grant_cnt;
    logic [7:0] r_timeout_cnt;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_grant_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (w_grant_start && r_grant_cnt != 8'hFF)   r_grant_cnt   <= r_grant_cnt + 8'd1;
            if (w_timeout && r_timeout_cnt != 8'hFF)     r_timeout_cnt <= r_timeout_cnt + 8'd1;
        end
    end

    assign grant_cnt   = r_grant_cnt;
    assign timeout_cnt = r_timeout_cnt;
`else
    logic w_unused;
    assign w_unused = w_grant_start;
`endif

    assign dig         = r_dig;
    assign busy        = (r_state != IDLE);
    assign owner       = r_owner;
    assign done        = r_done;
    assign ack_timeout = r_ack_timeout;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_lemming_dig_scheduler.sv
module tb_lemming_dig_scheduler;

    logic       clk;
    logic       areset;
    logic [3:0] req;
    logic [3:0] digging;
    logic [3:0] dig;
    logic       busy;
    logic [1:0] owner;
    logic       done;
    logic       ack_timeout;
    logic       overrun;
`ifdef DIG_SCHED_STATS_EN
    logic [7:0] grant_cnt;
    logic [7:0] timeout_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    lemming_dig_scheduler #(.N(4), .ACK_TIMEOUT(4), .MAX_DIG(20), .COOLDOWN(2)) dut (
        .clk         (clk),
        .areset      (areset),
        .req         (req),
        .digging     (digging),
        .dig         (dig),
        .busy        (busy),
        .owner       (owner),
        .done        (done),
        .ack_timeout (ack_timeout),
        .overrun     (overrun)
`ifdef DIG_SCHED_STATS_EN
        ,
        .grant_cnt   (grant_cnt),
        .timeout_cnt (timeout_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After this, the next tick() is "edge 1".
    task automatic do_reset();
        areset  = 1'b1;
        req     = 4'b0000;
        digging = 4'b0000;
        tick();
        tick();
        areset  = 1'b0;
    endtask

    task automatic test_reset();
        areset  = 1'b1;
        req     = 4'b1111;
        digging = 4'b1111;
        tick();
        n_cmp++; if (dig !== 4'b0000) begin n_err++; $display("FAIL reset_dig: got %b want 0000", dig); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL reset_owner: got %0d want 0", owner); end
        n_cmp++; if ({done, ack_timeout, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {done, ack_timeout, overrun}); end
    endtask

    task automatic test_basic_grant();
        do_reset();
        req = 4'b0110;
        tick(); // edge 1: GRANT, owner 1, dig not yet driven
        req = 4'b0000; // requests are not latched; grant continues
        n_cmp++; if (owner !== 2'd1) begin n_err++; $display("FAIL basic_owner: got %0d want 1", owner); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_grant: got %b want 1", busy); end
        n_cmp++; if (dig !== 4'b0000) begin n_err++; $display("FAIL basic_dig_e1: got %b want 0000", dig); end
        tick(); // edge 2
        n_cmp++; if (dig !== 4'b0010) begin n_err++; $display("FAIL basic_dig_e2: got %b want 0010", dig); end
        digging = 4'b1011; // non-owner bits must be ignored later
        tick(); // edge 3: ACTIVE
        n_cmp++; if (dig !== 4'b0000) begin n_err++; $display("FAIL basic_dig_active: got %b want 0000", dig); end
        repeat (4) tick(); // edges 4..7
        digging = 4'b1001; // owner drops, others stay high
        tick(); // edge 8
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", done); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL basic_no_overrun: got %b want 0", overrun); end
        tick(); // edge 9
        n_cmp++; if ({done, busy} !== 2'b01) begin n_err++; $display("FAIL basic_cool_e9: got %b want 01", {done, busy}); end
        tick(); // edge 10
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_cool_e10: got %b want 1", busy); end
        tick(); // edge 11
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_e11: got %b want 0", busy); end
        n_cmp++; if (owner !== 2'd1) begin n_err++; $display("FAIL basic_owner_hold: got %0d want 1", owner); end
        digging = 4'b0000;
    endtask

    task automatic test_round_robin();
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_dig;
        int k;
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            k = 0;
            while (dig == 4'b0000 && k < 20) begin
                tick();
                k++;
                n_cmp++; if ($countones(dig) > 1) begin n_err++; $display("FAIL rr_multihot: got %b", dig); end
            end
            exp_dig = 4'b0001 << exp_rr[g];
            n_cmp++; if (dig !== exp_dig) begin n_err++; $display("FAIL rr_dig_%0d: got %b want %b", g, dig, exp_dig); end
            n_cmp++; if (owner !== 2'(exp_rr[g])) begin n_err++; $display("FAIL rr_owner_%0d: got %0d want %0d", g, owner, exp_rr[g]); end
            digging = exp_dig;
            repeat (3) tick();
            digging = 4'b0000;
            tick();
            n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rr_done_%0d: got %b want 1", g, done); end
        end
        req = 4'b0000;
    endtask

    task automatic test_ack_timeout();
        logic [3:0] exp_dig;
        logic       exp_to;
        do_reset();
        req = 4'b1000;
        tick(); // edge 1
        n_cmp++; if (owner !== 2'd3) begin n_err++; $display("FAIL to_owner: got %0d want 3", owner); end
        for (int c = 2; c <= 9; c++) begin
            tick();
            exp_dig = (c >= 2 && c <= 5) ? 4'b1000 : 4'b0000;
            exp_to  = (c == 6);
            n_cmp++; if (dig !== exp_dig) begin n_err++; $display("FAIL to_dig_e%0d: got %b want %b", c, dig, exp_dig); end
            n_cmp++; if (ack_timeout !== exp_to) begin n_err++; $display("FAIL to_pulse_e%0d: got %b want %b", c, ack_timeout, exp_to); end
            n_cmp++; if (busy !== (c <= 8)) begin n_err++; $display("FAIL to_busy_e%0d: got %b want %b", c, busy, (c <= 8)); end
            if (c == 8) req = 4'b1001; // lemming 0 now competes; last owner was 3
        end
        tick(); // edge 10: wrap-around pick goes to 0
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL to_next_owner: got %0d want 0", owner); end
        req = 4'b0000;
    endtask

    task automatic test_overrun();
        logic exp_ovr;
        logic exp_done;
        do_reset();
        req = 4'b0001;
        tick(); // edge 1
        tick(); // edge 2
        digging = 4'b0001;
        req = 4'b0000;
        tick(); // edge 3: ACTIVE entry
        for (int c = 4; c <= 29; c++) begin
            tick();
            exp_ovr  = (c == 23);
            exp_done = (c == 28);
            n_cmp++; if (overrun !== exp_ovr) begin n_err++; $display("FAIL ovr_pulse_e%0d: got %b want %b", c, overrun, exp_ovr); end
            n_cmp++; if (done !== exp_done) begin n_err++; $display("FAIL ovr_done_e%0d: got %b want %b", c, done, exp_done); end
            if (c == 27) digging = 4'b0000;
        end
    endtask

    task automatic test_done_with_overrun();
        do_reset();
        req = 4'b0100;
        tick(); // edge 1
        tick(); // edge 2
        digging = 4'b0100;
        req = 4'b0000;
        tick(); // edge 3: ACTIVE entry
        repeat (19) tick(); // edges 4..22
        digging = 4'b0000;
        tick(); // edge 23: length hits 20 and owner drops together
        n_cmp++; if ({done, overrun} !== 2'b11) begin n_err++; $display("FAIL both_pulses: got %b want 11", {done, overrun}); end
    endtask

    task automatic test_reset_mid_active();
        do_reset();
        req = 4'b0010;
        tick(); // edge 1
        tick(); // edge 2
        digging = 4'b0010;
        req = 4'b0000;
        tick(); // edge 3: ACTIVE
        tick(); // edge 4
        digging = 4'b0000;
        tick(); // edge 5: done pulse
        n_cmp++; if ({done, busy} !== 2'b11) begin n_err++; $display("FAIL mid_pre_reset: got %b want 11", {done, busy}); end
        #2 areset = 1'b1;
        #1;
        n_cmp++; if ({dig, busy, done, ack_timeout, overrun} !== 8'b0) begin n_err++; $display("FAIL mid_async_clear: got %b want 0", {dig, busy, done, ack_timeout, overrun}); end
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL mid_owner: got %0d want 0", owner); end
        #1 areset = 1'b0;
        req = 4'b1111;
        tick();
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL mid_next_owner: got %0d want 0", owner); end
        req = 4'b0000;
    endtask

`ifdef DIG_SCHED_STATS_EN
    task automatic test_stats();
        int nto;
        int k;
        do_reset();
        n_cmp++; if ({grant_cnt, timeout_cnt} !== 16'h0) begin n_err++; $display("FAIL stats_reset: got %h want 0000", {grant_cnt, timeout_cnt}); end
        req = 4'b1000;
        nto = 0;
        k = 0;
        while (nto < 300 && k < 4000) begin
            tick();
            k++;
            if (ack_timeout) begin
                nto++;
                if (nto == 10) begin
                    n_cmp++; if (grant_cnt !== 8'd10) begin n_err++; $display("FAIL stats_grant10: got %0d want 10", grant_cnt); end
                    n_cmp++; if (timeout_cnt !== 8'd10) begin n_err++; $display("FAIL stats_to10: got %0d want 10", timeout_cnt); end
                end
            end
        end
        n_cmp++; if (nto !== 300) begin n_err++; $display("FAIL stats_budget: got %0d timeouts want 300", nto); end
        n_cmp++; if (timeout_cnt !== 8'd255) begin n_err++; $display("FAIL stats_to_sat: got %0d want 255", timeout_cnt); end
        n_cmp++; if (grant_cnt !== 8'd255) begin n_err++; $display("FAIL stats_grant_sat: got %0d want 255", grant_cnt); end
        req = 4'b0000;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        areset  = 1'b1;
        req     = 4'b0000;
        digging = 4'b0000;
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_ack_timeout();
        test_overrun();
        test_done_with_overrun();
        test_reset_mid_active();
`ifdef DIG_SCHED_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
